// File: rtl/player_grid_mover.sv
// player_grid_mover
// Tile-locked player motion controller. Each accepted keypress moves the player
// sprite exactly one tile, advancing SPEED pixels per video frame. A wall hit
// on the leading edge aborts the move and walks the sprite back to its origin tile.
//
// Ports:
//   clk            system clock
//   resetN         synchronous active-low reset
//   startOfFrame   one-cycle pulse per video frame; all motion happens on it
//   keyUp/Down/Left/Right  level inputs, 1 = pressed (priority Up > Down > Left > Right)
//   collision      player bitmap overlaps a wall pixel this cycle
//   HitEdgeCode    edge hit: 0 bottom, 1 left, 2 right, 3 top (bits [3:2] must be 0)
//   topLeftX/Y     sprite top-left position in pixels
//   moving         1 while moving forward or bouncing back
//   direction      latched direction: 0 down, 1 left, 2 right, 3 up
//
// Configuration macro:
//   PLAYER_MOVE_QUEUE_EN  when defined, a key seen during a move is held in a
//                         one-entry queue and started as soon as that move completes.

module player_grid_mover #(
   parameter int unsigned INIT_TILE_X = 1,
   parameter int unsigned INIT_TILE_Y = 1,
   parameter int unsigned TILE_LOG2   = 5,
   parameter int unsigned SPEED       = 2,
   parameter int unsigned MAP_TILES_X = 20,
   parameter int unsigned MAP_TILES_Y = 15
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        keyUp,
   input  logic        keyDown,
   input  logic        keyLeft,
   input  logic        keyRight,
   input  logic        collision,
   input  logic [3:0]  HitEdgeCode,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic        moving,
   output logic [1:0]  direction
);

   localparam int unsigned CW     = TILE_LOG2 + 1;
   localparam int unsigned TILE_PX = 1 << TILE_LOG2;

   localparam logic [10:0]   STEP_PX   = 11'(SPEED);
   localparam logic [CW-1:0] CNT_SPEED = CW'(SPEED);
   localparam logic [CW-1:0] CNT_TILE  = CW'(TILE_PX);
   localparam logic [10:0]   INIT_X    = 11'(INIT_TILE_X * TILE_PX);
   localparam logic [10:0]   INIT_Y    = 11'(INIT_TILE_Y * TILE_PX);
   localparam logic [10:0]   MAX_TX    = 11'(MAP_TILES_X - 1);
   localparam logic [10:0]   MAX_TY    = 11'(MAP_TILES_Y - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_MOVE   = 2'd1;
   localparam logic [1:0] ST_BOUNCE = 2'd2;

   localparam logic [1:0] DIR_DOWN  = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_RIGHT = 2'd2;
   localparam logic [1:0] DIR_UP    = 2'd3;

   logic [1:0]    r_state, w_state_nx;
   logic [10:0]   r_x, w_x_nx;
   logic [10:0]   r_y, w_y_nx;
   logic [1:0]    r_dir, w_dir_nx;
   logic [CW-1:0] r_step, w_step_nx;
   logic          r_hit;
   logic          r_moving;

   logic          w_key_vld;
   logic [1:0]    w_key_dir;
   logic          w_hit_set;
   logic [10:0]   w_fwd_x, w_fwd_y, w_back_x, w_back_y;
   logic [CW-1:0] w_step_add;

`ifdef PLAYER_MOVE_QUEUE_EN
   logic          r_q_vld, w_q_vld_nx;
   logic [1:0]    r_q_dir, w_q_dir_nx;
   logic          w_take_vld;
   logic [1:0]    w_take_dir;
`endif

   // Position is tile-aligned whenever this is evaluated, so the shift gives the tile index.
   function automatic logic target_ok(input logic [1:0] dir, input logic [10:0] x,
                                      input logic [10:0] y);
      logic [10:0] tx;
      logic [10:0] ty;
      logic        ok;
      tx = x >> TILE_LOG2;
      ty = y >> TILE_LOG2;
      case (dir)
         DIR_DOWN:  ok = (ty < MAX_TY);
         DIR_LEFT:  ok = (tx != 11'd0);
         DIR_RIGHT: ok = (tx < MAX_TX);
         default:   ok = (ty != 11'd0);
      endcase
      return ok;
   endfunction

   always_comb begin
      w_key_vld = keyUp | keyDown | keyLeft | keyRight;
      w_key_dir = DIR_DOWN;
      if (keyUp)         w_key_dir = DIR_UP;
      else if (keyDown)  w_key_dir = DIR_DOWN;
      else if (keyLeft)  w_key_dir = DIR_LEFT;
      else if (keyRight) w_key_dir = DIR_RIGHT;
   end

   // Only a hit on the leading edge of the current move blocks it.
   assign w_hit_set = collision && (r_state == ST_MOVE) &&
                      (HitEdgeCode[1:0] == r_dir) && (HitEdgeCode[3:2] == 2'b00);

   always_comb begin
      w_fwd_x  = r_x;
      w_fwd_y  = r_y;
      w_back_x = r_x;
      w_back_y = r_y;
      unique case (r_dir)
         DIR_DOWN:  begin w_fwd_y = r_y + STEP_PX; w_back_y = r_y - STEP_PX; end
         DIR_LEFT:  begin w_fwd_x = r_x - STEP_PX; w_back_x = r_x + STEP_PX; end
         DIR_RIGHT: begin w_fwd_x = r_x + STEP_PX; w_back_x = r_x - STEP_PX; end
         DIR_UP:    begin w_fwd_y = r_y - STEP_PX; w_back_y = r_y + STEP_PX; end
      endcase
   end

   assign w_step_add = r_step + CNT_SPEED;

`ifdef PLAYER_MOVE_QUEUE_EN
   // A key on the completing frame itself overrides the older queued one.
   assign w_take_vld = w_key_vld | r_q_vld;
   assign w_take_dir = w_key_vld ? w_key_dir : r_q_dir;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_x_nx     = r_x;
      w_y_nx     = r_y;
      w_dir_nx   = r_dir;
      w_step_nx  = r_step;
`ifdef PLAYER_MOVE_QUEUE_EN
      w_q_vld_nx = r_q_vld;
      w_q_dir_nx = r_q_dir;
`endif
      if (startOfFrame) begin
         case (r_state)
            ST_IDLE: begin
               if (w_key_vld && target_ok(w_key_dir, r_x, r_y)) begin
                  w_state_nx = ST_MOVE;
                  w_dir_nx   = w_key_dir;
                  w_step_nx  = '0;
               end
            end
            ST_MOVE: begin
               if (r_hit) begin
                  w_state_nx = ST_BOUNCE;
`ifdef PLAYER_MOVE_QUEUE_EN
                  w_q_vld_nx = 1'b0;
`endif
               end else begin
                  w_x_nx    = w_fwd_x;
                  w_y_nx    = w_fwd_y;
                  w_step_nx = w_step_add;
`ifdef PLAYER_MOVE_QUEUE_EN
                  if (w_key_vld) begin
                     w_q_vld_nx = 1'b1;
                     w_q_dir_nx = w_key_dir;
                  end
`endif
                  if (w_step_add == CNT_TILE) begin
                     w_step_nx  = '0;
                     w_state_nx = ST_IDLE;
`ifdef PLAYER_MOVE_QUEUE_EN
                     w_q_vld_nx = 1'b0;
                     if (w_take_vld && target_ok(w_take_dir, w_fwd_x, w_fwd_y)) begin
                        w_state_nx = ST_MOVE;
                        w_dir_nx   = w_take_dir;
                     end
`endif
                  end
               end
            end
            ST_BOUNCE: begin
               // A hit on the very first frame leaves nothing to undo.
               if (r_step == '0) begin
                  w_state_nx = ST_IDLE;
               end else begin
                  w_x_nx    = w_back_x;
                  w_y_nx    = w_back_y;
                  w_step_nx = r_step - CNT_SPEED;
                  if (r_step == CNT_SPEED) w_state_nx = ST_IDLE;
               end
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state  <= ST_IDLE;
         r_x      <= INIT_X;
         r_y      <= INIT_Y;
         r_dir    <= DIR_DOWN;
         r_step   <= '0;
         r_hit    <= 1'b0;
         r_moving <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_x      <= w_x_nx;
         r_y      <= w_y_nx;
         r_dir    <= w_dir_nx;
         r_step   <= w_step_nx;
         r_moving <= (w_state_nx != ST_IDLE);
         // Set has priority so a hit on the frame boundary counts for the new frame.
         if (w_hit_set)         r_hit <= 1'b1;
         else if (startOfFrame) r_hit <= 1'b0;
      end
   end

`ifdef PLAYER_MOVE_QUEUE_EN
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_q_vld <= 1'b0;
         r_q_dir <= DIR_DOWN;
      end else begin
         r_q_vld <= w_q_vld_nx;
         r_q_dir <= w_q_dir_nx;
      end
   end
`endif

   assign topLeftX  = r_x;
   assign topLeftY  = r_y;
   assign moving    = r_moving;
   assign direction = r_dir;

endmodule

// File: tb/tb_player_grid_mover.sv
// Bench for player_grid_mover. Stimulus issues frames and pushes the expected
// post-frame outputs; a monitor pops and compares after every frame or reset check.

module tb_player_grid_mover;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        mv;
      logic [1:0]  dir;
   } exp_t;

   logic        clk;
   logic        resetN;
   logic        sof;
   logic        k_up, k_down, k_left, k_right;
   logic        collision;
   logic [3:0]  hit_code;
   logic [10:0] top_x, top_y;
   logic        moving;
   logic [1:0]  direction;
   logic        chk;

   exp_t  q_exp[$];
   string q_tag[$];
   int    n_tests;
   int    n_fail;
   int    ex, ey;

   player_grid_mover dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (sof),
      .keyUp        (k_up),
      .keyDown      (k_down),
      .keyLeft      (k_left),
      .keyRight     (k_right),
      .collision    (collision),
      .HitEdgeCode  (hit_code),
      .topLeftX     (top_x),
      .topLeftY     (top_y),
      .moving       (moving),
      .direction    (direction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every frame pulse or reset check yields one observed response.
   always @(posedge clk) begin
      if (sof || chk) begin
         exp_t  e;
         exp_t  got;
         string tag;
         @(negedge clk);
         got = '{x: top_x, y: top_y, mv: moving, dir: direction};
         n_tests++;
         if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_sample: got x=%0d y=%0d mv=%0b dir=%0d, no expectation queued",
                     got.x, got.y, got.mv, got.dir);
         end else begin
            e   = q_exp.pop_front();
            tag = q_tag.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL %s: got x=%0d y=%0d mv=%0b dir=%0d, want x=%0d y=%0d mv=%0b dir=%0d",
                        tag, got.x, got.y, got.mv, got.dir, e.x, e.y, e.mv, e.dir);
            end
         end
      end
   end

   task automatic set_keys(input logic [3:0] k);
      {k_up, k_down, k_left, k_right} = k;
   endtask

   task automatic expect_out(input string tag, input int x, input int y, input logic mv,
                             input logic [1:0] d);
      q_exp.push_back('{x: 11'(x), y: 11'(y), mv: mv, dir: d});
      q_tag.push_back(tag);
   endtask

   // Called at a negedge; returns at a negedge three cycles later.
   task automatic frame(input string tag, input int x, input int y, input logic mv,
                        input logic [1:0] d);
      expect_out(tag, x, y, mv, d);
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_hit(input logic [3:0] code);
      collision = 1'b1;
      hit_code  = code;
      @(negedge clk);
      collision = 1'b0;
      hit_code  = 4'd0;
   endtask

   // One full tile move: entry frame, then 16 steps of 2 px.
   task automatic move_tile(input string tag, input logic [3:0] keys, input logic [1:0] d);
      int dx, dy;
      dx = 0;
      dy = 0;
      case (d)
         2'd0: dy = 1;
         2'd1: dx = -1;
         2'd2: dx = 1;
         default: dy = -1;
      endcase
      set_keys(keys);
      frame(tag, ex, ey, 1'b1, d);
      set_keys(4'b0000);
      for (int k = 1; k <= 16; k++) begin
         frame(tag, ex + dx * 2 * k, ey + dy * 2 * k, (k < 16), d);
      end
      ex = ex + dx * 32;
      ey = ey + dy * 32;
   endtask

   task automatic blocked(input string tag, input logic [3:0] keys, input logic [1:0] d);
      set_keys(keys);
      for (int k = 0; k < 4; k++) frame(tag, ex, ey, 1'b0, d);
      set_keys(4'b0000);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      resetN    = 1'b0;
      sof       = 1'b0;
      chk       = 1'b0;
      collision = 1'b0;
      hit_code  = 4'd0;
      set_keys(4'b0000);
      @(negedge clk);
      @(negedge clk);
      expect_out("reset_state", 32, 32, 1'b0, 2'd0);
      chk = 1'b1;
      @(negedge clk);
      chk    = 1'b0;
      resetN = 1'b1;
      ex     = 32;
      ey     = 32;

      frame("idle_no_key", 32, 32, 1'b0, 2'd0);

      // Right move from (1,1) to (2,1): X 34..64.
      move_tile("right_move", 4'b0001, 2'd2);
      frame("right_settled", 64, 32, 1'b0, 2'd2);

      // Up move aborted by a top-edge hit; non-matching hits are ignored.
      set_keys(4'b1000);
      frame("bounce_start", 64, 32, 1'b1, 2'd3);
      set_keys(4'b0000);
      frame("bounce_fwd1", 64, 30, 1'b1, 2'd3);
      pulse_hit(4'd0);
      frame("bounce_fwd2_wrong_edge", 64, 28, 1'b1, 2'd3);
      pulse_hit(4'b0111);
      frame("bounce_fwd3_hi_bits", 64, 26, 1'b1, 2'd3);
      pulse_hit(4'd3);
      frame("bounce_enter", 64, 26, 1'b1, 2'd3);
      frame("bounce_back1", 64, 28, 1'b1, 2'd3);
      frame("bounce_back2", 64, 30, 1'b1, 2'd3);
      frame("bounce_done", 64, 32, 1'b0, 2'd3);
      frame("bounce_idle", 64, 32, 1'b0, 2'd3);

      // Walk to the left edge and check it holds.
      move_tile("to_left_a", 4'b0010, 2'd1);
      move_tile("to_left_b", 4'b0010, 2'd1);
      blocked("left_edge", 4'b0010, 2'd1);

      // Up beats Left and Right when pressed together.
      move_tile("priority_up", 4'b1011, 2'd3);
      blocked("top_edge", 4'b1000, 2'd3);

      // Walk to column 19 and check the right edge.
      for (int i = 0; i < 19; i++) move_tile("to_right", 4'b0001, 2'd2);
      blocked("right_edge", 4'b0001, 2'd2);

      // Reset in the middle of a down move.
      set_keys(4'b0100);
      frame("rst_move_start", 608, 0, 1'b1, 2'd0);
      set_keys(4'b0000);
      for (int k = 1; k <= 5; k++) frame("rst_move_step", 608, 2 * k, 1'b1, 2'd0);
      resetN = 1'b0;
      expect_out("reset_mid_move", 32, 32, 1'b0, 2'd0);
      chk = 1'b1;
      @(negedge clk);
      chk    = 1'b0;
      resetN = 1'b1;
      frame("after_reset_idle", 32, 32, 1'b0, 2'd0);
      ex = 32;
      ey = 32;

      // Key pressed mid-move: queued down move only when the queue is built.
      set_keys(4'b0001);
      frame("queue_start", 32, 32, 1'b1, 2'd2);
      set_keys(4'b0000);
      for (int k = 1; k < 16; k++) begin
         if (k == 8) k_down = 1'b1;
         frame("queue_step", 32 + 2 * k, 32, 1'b1, 2'd2);
         k_down = 1'b0;
      end
`ifdef PLAYER_MOVE_QUEUE_EN
      frame("queue_complete", 64, 32, 1'b1, 2'd0);
      frame("queue_next_step", 64, 34, 1'b1, 2'd0);
`else
      frame("queue_complete", 64, 32, 1'b0, 2'd2);
      frame("queue_next_step", 64, 32, 1'b0, 2'd2);
`endif

      repeat (4) @(negedge clk);
      n_tests++;
      if (q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unobserved expectations, want 0", q_exp.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
